// File: rtl/pwm_ramp_ctrl_pkg.sv
// pwm_ramp_ctrl_pkg
//   Shared constants, types and helpers for the PWM duty ramp controller.
//   DUTY_MAX      : full-scale duty in percent
//   MODE_*        : encodings of the iMODE input
//   state_t       : controller FSM states
//   CLogB2        : bits needed to represent a value (used for port widths)
//   clamp_pct     : saturate a 7-bit percentage at DUTY_MAX
package pwm_ramp_ctrl_pkg;

  localparam logic [6:0] DUTY_MAX     = 7'd100;
  localparam logic       MODE_ONESHOT = 1'b0;
  localparam logic       MODE_BREATHE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    BR_UP = 2'd2,
    BR_DN = 2'd3
  } state_t;

  function automatic int CLogB2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic logic [6:0] clamp_pct(input logic [6:0] d);
    return (d > DUTY_MAX) ? DUTY_MAX : d;
  endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_step_tick.sv
// step_tick
//   Step prescaler: counts 0..div-1 and asserts tick for the cycle in which
//   the count sits at div-1, then wraps to 0. clear restarts the count at 0,
//   so the first tick after a clear lands div cycles later.
//   iCLK  : system clock, rising edge
//   iRST  : synchronous active-high reset (count = 0)
//   clear : restart the count from 0
//   div   : cycles per tick, must be non-zero
//   tick  : one-cycle step strobe
module step_tick #(
  parameter int STEP_BITS = 24
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 clear,
  input  logic [STEP_BITS-1:0] div,
  output logic                 tick
);

  logic [STEP_BITS-1:0] count;

  assign tick = (count == (div - STEP_BITS'(1)));

  always_ff @(posedge iCLK) begin
    if (iRST || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + STEP_BITS'(1);
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
//   Drives frequency and duty to a PWM generator. On start it either ramps
//   the duty one percent per step toward a target (one-shot) or bounces it
//   between two bounds (breathe) until stopped.
//   iCLK, iRST   : clock, synchronous active-high reset
//   iSTART/iSTOP : start (idle only) / stop (busy only) requests
//   iMODE        : 0 one-shot ramp, 1 breathe
//   iTARGET      : one-shot target duty in percent
//   iDUTY_LO/HI  : breathe bounds in percent
//   iSTEP_DIV    : clock cycles per 1% step (0 treated as 1)
//   iFREQ        : requested PWM frequency in Hz
//   oPWM_freq    : registered PWM frequency
//   oduty_cycle  : registered duty 0..100
//   oBUSY        : high while ramping or breathing
//   oDONE        : one-cycle pulse on completion or stop
module pwm_ramp_ctrl
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter int SYSCLK_FRQ = 50000000,
  parameter int freq_min   = 1,
  parameter int freq_max   = 10000,
  parameter int nbits_freq = CLogB2(freq_max),
  parameter int STEP_BITS  = 24
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iSTART,
  input  logic                  iSTOP,
  input  logic                  iMODE,
  input  logic [6:0]            iTARGET,
  input  logic [6:0]            iDUTY_LO,
  input  logic [6:0]            iDUTY_HI,
  input  logic [STEP_BITS-1:0]  iSTEP_DIV,
  input  logic [nbits_freq-1:0] iFREQ,
  output logic [nbits_freq-1:0] oPWM_freq,
  output logic [6:0]            oduty_cycle,
  output logic                  oBUSY,
  output logic                  oDONE
);

  // A PWM frequency above half the system clock cannot be produced, so the
  // upper clamp never exceeds that even if freq_max is configured higher.
  localparam int FMAX_EFF = (freq_max < SYSCLK_FRQ / 2) ? freq_max : SYSCLK_FRQ / 2;
  localparam logic [nbits_freq-1:0] FMIN = nbits_freq'(freq_min);
  localparam logic [nbits_freq-1:0] FMAX = nbits_freq'(FMAX_EFF);

  state_t               state;
  logic [6:0]           target_q, lo_q, hi_q;
  logic [STEP_BITS-1:0] step_div_q;
  logic                 latch, tick;

  logic [6:0]            tgt_in, lo_in, hi_in, br_start, ramp_next;
  logic [nbits_freq-1:0] freq_in;
  logic [STEP_BITS-1:0]  div_in;

  assign latch = iSTART && (state == IDLE);

  always_comb begin
    tgt_in = clamp_pct(iTARGET);
    lo_in  = clamp_pct(iDUTY_LO);
    hi_in  = clamp_pct(iDUTY_HI);
    if (iFREQ < FMIN)      freq_in = FMIN;
    else if (iFREQ > FMAX) freq_in = FMAX;
    else                   freq_in = iFREQ;
    div_in = (iSTEP_DIV == '0) ? STEP_BITS'(1) : iSTEP_DIV;
    if (oduty_cycle < lo_in)      br_start = lo_in;
    else if (oduty_cycle > hi_in) br_start = hi_in;
    else                          br_start = oduty_cycle;
    ramp_next = (oduty_cycle < target_q) ? oduty_cycle + 7'd1 : oduty_cycle - 7'd1;
  end

  step_tick #(.STEP_BITS(STEP_BITS)) u_step_tick (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .clear (latch),
    .div   (step_div_q),
    .tick  (tick)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state       <= IDLE;
      oduty_cycle <= '0;
      oPWM_freq   <= FMIN;
      oBUSY       <= 1'b0;
      oDONE       <= 1'b0;
      target_q    <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      step_div_q  <= STEP_BITS'(1);
    end else begin
      oDONE <= 1'b0;
      if (state == IDLE) begin
        if (iSTART) begin
          target_q   <= tgt_in;
          lo_q       <= lo_in;
          hi_q       <= hi_in;
          step_div_q <= div_in;
          oPWM_freq  <= freq_in;
          case (iMODE)
            MODE_ONESHOT: begin
              state <= RAMP;
              oBUSY <= 1'b1;
            end
            MODE_BREATHE: begin
              // An empty breathe window completes on the latch edge itself.
              if (lo_in >= hi_in) begin
                oduty_cycle <= lo_in;
                oDONE       <= 1'b1;
              end else begin
                // Starting at hi must head down, or the first step would leave the window.
                oduty_cycle <= br_start;
                state       <= (br_start == hi_in) ? BR_DN : BR_UP;
                oBUSY       <= 1'b1;
              end
            end
          endcase
        end
      end else if (iSTOP) begin
        state <= IDLE;
        oBUSY <= 1'b0;
        oDONE <= 1'b1;
      end else if (state == RAMP) begin
        if (oduty_cycle == target_q) begin
          state <= IDLE;
          oBUSY <= 1'b0;
          oDONE <= 1'b1;
        end else if (tick) begin
          oduty_cycle <= ramp_next;
          if (ramp_next == target_q) begin
            state <= IDLE;
            oBUSY <= 1'b0;
            oDONE <= 1'b1;
          end
        end
      end else if (state == BR_UP) begin
        if (tick && (oduty_cycle < hi_q)) begin
          oduty_cycle <= oduty_cycle + 7'd1;
          if ((oduty_cycle + 7'd1) == hi_q) state <= BR_DN;
        end
      end else begin
        if (tick && (oduty_cycle > lo_q)) begin
          oduty_cycle <= oduty_cycle - 7'd1;
          if ((oduty_cycle - 7'd1) == lo_q) state <= BR_UP;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
module tb_pwm_ramp_ctrl;

  localparam int NBF = 14;
  localparam int SB  = 24;

  logic           clk = 1'b0;
  logic           rst = 1'b0, start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [6:0]     target = '0, lo = '0, hi = '0;
  logic [SB-1:0]  div = '0;
  logic [NBF-1:0] freq = '0;
  logic [NBF-1:0] pwm_freq;
  logic [6:0]     duty;
  logic           busy, done;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(
    .SYSCLK_FRQ (50000000),
    .freq_min   (1),
    .freq_max   (10000),
    .nbits_freq (NBF),
    .STEP_BITS  (SB)
  ) dut (
    .iCLK        (clk),
    .iRST        (rst),
    .iSTART      (start),
    .iSTOP       (stop),
    .iMODE       (mode),
    .iTARGET     (target),
    .iDUTY_LO    (lo),
    .iDUTY_HI    (hi),
    .iSTEP_DIV   (div),
    .iFREQ       (freq),
    .oPWM_freq   (pwm_freq),
    .oduty_cycle (duty),
    .oBUSY       (busy),
    .oDONE       (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference model: duty moves on every multiple of the step divider,
  // counted in cycles since the start was accepted.
  int m_duty, m_freq, m_tgt, m_lo, m_hi, m_div, m_cnt, m_dir;
  bit m_busy, m_done, m_breathe, m_valid = 1'b0;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_valid = 1'b1;
      m_duty  = 0;
      m_freq  = 1;
      m_busy  = 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_tgt  = imin(int'(target), 100);
        m_lo   = imin(int'(lo), 100);
        m_hi   = imin(int'(hi), 100);
        m_div  = (div == 0) ? 1 : int'(div);
        m_freq = imax(1, imin(int'(freq), 10000));
        m_cnt  = 0;
        if (mode == 1'b0) begin
          m_busy    = 1'b1;
          m_breathe = 1'b0;
        end else if (m_lo >= m_hi) begin
          m_duty = m_lo;
          m_done = 1'b1;
        end else begin
          m_duty    = imax(m_lo, imin(m_hi, m_duty));
          m_busy    = 1'b1;
          m_breathe = 1'b1;
          m_dir     = (m_duty == m_hi) ? -1 : 1;
        end
      end
    end else begin
      m_cnt++;
      if (stop) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end else if (!m_breathe) begin
        if (m_duty == m_tgt) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end else if (m_cnt % m_div == 0) begin
          m_duty += (m_tgt > m_duty) ? 1 : -1;
          if (m_duty == m_tgt) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      end else if (m_cnt % m_div == 0) begin
        m_duty += m_dir;
        if (m_duty == m_hi) m_dir = -1;
        if (m_duty == m_lo) m_dir = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_duty", duty, m_duty);
      check("model_freq", pwm_freq, m_freq);
      check("model_busy", busy, m_busy);
      check("model_done", done, m_done);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic md, input int tg, input int l, input int h,
                    input int dv, input int fq);
    mode   = md;
    target = 7'(tg);
    lo     = 7'(l);
    hi     = 7'(h);
    div    = SB'(dv);
    freq   = NBF'(fq);
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  initial begin
    int dcount;
    int seen;
    int bseq[8];
    bseq = '{10, 11, 12, 11, 10, 11, 12, 11};

    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_duty", duty, 0);
    check("rst_freq", pwm_freq, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // one-shot ramp 0 -> 5, four cycles per step
    go(1'b0, 5, 0, 0, 4, 1000);
    check("ramp_latch_busy", busy, 1);
    check("ramp_latch_freq", pwm_freq, 1000);
    dcount = 0;
    for (int k = 1; k <= 24; k++) begin
      step();
      check("ramp_up_duty", duty, imin(k / 4, 5));
      check("ramp_up_done", done, (k == 20));
      if (done) dcount++;
    end
    check("ramp_up_done_count", dcount, 1);

    // breathe 10..12, one cycle per step, then stop
    go(1'b1, 0, 10, 12, 1, 1000);
    check("br_seq_first", duty, bseq[0]);
    for (int k = 1; k < 8; k++) begin
      step();
      check("br_seq", duty, bseq[k]);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("br_stop_duty", duty, 11);
    check("br_stop_done", done, 1);
    check("br_stop_busy", busy, 0);
    step();
    check("br_stop_done_once", done, 0);
    check("br_stop_frozen", duty, 11);

    // clamping: target 120 -> 100, frequency above max -> 10000
    go(1'b0, 120, 0, 0, 0, 16383);
    check("clamp_freq_hi", pwm_freq, 10000);
    seen = 0;
    for (int k = 0; k < 200 && seen == 0; k++) begin
      step();
      if (done) seen = 1;
    end
    check("clamp_ramp_finished", seen, 1);
    check("clamp_duty", duty, 100);

    // target equals current duty, frequency 0 -> 1
    go(1'b0, 100, 0, 0, 3, 0);
    check("eq_freq_lo", pwm_freq, 1);
    check("eq_busy", busy, 1);
    check("eq_done_early", done, 0);
    step();
    check("eq_done", done, 1);
    check("eq_busy_after", busy, 0);
    check("eq_duty", duty, 100);

    // start while busy is ignored; stop on the final step gives one done
    go(1'b0, 90, 0, 0, 2, 500);
    step();
    step();
    start = 1'b1;
    mode  = 1'b1;
    freq  = NBF'(3000);
    lo    = 7'd20;
    hi    = 7'd40;
    step();
    start = 1'b0;
    check("busy_start_freq", pwm_freq, 500);
    check("busy_start_busy", busy, 1);
    repeat (16) step();
    check("conf_pre_final", duty, 91);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("conf_stop_done", done, 1);
    check("conf_stop_busy", busy, 0);
    check("conf_stop_duty", duty, 91);
    dcount = 0;
    repeat (5) begin
      step();
      if (done) dcount++;
    end
    check("conf_single_done", dcount, 0);

    // reset mid-ramp overrides coincident start and stop
    go(1'b0, 0, 0, 0, 3, 777);
    repeat (7) step();
    check("mid_busy", busy, 1);
    check("mid_duty", duty, 89);
    rst   = 1'b1;
    start = 1'b1;
    stop  = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    check("mid_rst_duty", duty, 0);
    check("mid_rst_freq", pwm_freq, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);

    // degenerate breathe window and zero divider
    go(1'b1, 0, 50, 50, 1, 1000);
    check("degen_duty", duty, 50);
    check("degen_done", done, 1);
    check("degen_busy", busy, 0);
    step();
    check("degen_done_once", done, 0);
    go(1'b0, 53, 0, 0, 0, 1000);
    for (int k = 1; k <= 3; k++) begin
      step();
      check("div0_duty", duty, 50 + k);
    end
    check("div0_done", done, 1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      start  = ($urandom_range(0, 19) == 0);
      stop   = ($urandom_range(0, 39) == 0);
      mode   = 1'($urandom_range(0, 1));
      target = 7'($urandom_range(0, 127));
      lo     = 7'($urandom_range(0, 110));
      hi     = 7'($urandom_range(0, 127));
      div    = SB'($urandom_range(0, 4));
      freq   = NBF'($urandom_range(0, 16383));
      step();
    end
    rst   = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
